frog_game_ctrl: RTL and testbench

Top-level sequencer for the lane-based crossing game. It generates per-lane obstacle init patterns from an LFSR and holds all lanes in reset while loading them. It then drives the shared obstacle speed and tracks lives and level. It consumes the OR-reduced lane lose flags and a goal-reached flag to decide between retry, level-up, game over and win.

---
 rtl/frog_game_ctrl_pkg.sv | 25 ++
 rtl/frog_game_ctrl_if.sv | 47 ++++
 rtl/frog_lfsr16.sv | 26 ++
 rtl/frog_game_ctrl.sv | 172 +++++++++++++++++
 tb/tb_frog_game_ctrl.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/frog_game_ctrl_pkg.sv
// Shared types and LFSR helpers for the frog crossing game sequencer.
// The score counter is present only when SCORE_EN is defined.
package frog_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ARM,
        RUN,
        HIT,
        OVER,
        WIN
    } state_t;

    localparam logic [15:0] LFSR_MASK = 16'hB400;
    localparam logic [15:0] GAP_MASK  = 16'h7777;

    // Galois step: shift right, fold the tap mask in when a one falls out
    function automatic logic [15:0] next_lfsr(input logic [15:0] cur);
        logic [15:0] shifted;
        shifted = {1'b0, cur[15:1]};
        return cur[0] ? (shifted ^ LFSR_MASK) : shifted;
    endfunction

endpackage

// File: rtl/frog_game_ctrl_if.sv
// Sequencer-to-lanes signal bundle; master is the controller, slave the game fabric.
// The score signal exists only when SCORE_EN is defined.
interface frog_game_ctrl_if #(
    parameter int NUM_LANES = 8,
    parameter int LANE_W    = 16
);

    logic                        start;
    logic                        lose_any;
    logic                        goal;
    logic                        lane_reset;
    logic [NUM_LANES*LANE_W-1:0] init_bus;
    logic [7:0]                  speed;
    logic [3:0]                  level;
    logic [2:0]                  lives;
    logic                        play_en;
    logic                        game_over;
    logic                        win;
`ifdef SCORE_EN
    logic [15:0]                 score;

    modport master (
        input  start, lose_any, goal,
        output lane_reset, init_bus, speed, level, lives,
        output play_en, game_over, win, score
    );

    modport slave (
        output start, lose_any, goal,
        input  lane_reset, init_bus, speed, level, lives,
        input  play_en, game_over, win, score
    );
`else
    modport master (
        input  start, lose_any, goal,
        output lane_reset, init_bus, speed, level, lives,
        output play_en, game_over, win
    );

    modport slave (
        output start, lose_any, goal,
        input  lane_reset, init_bus, speed, level, lives,
        input  play_en, game_over, win
    );
`endif

endinterface

// File: rtl/frog_lfsr16.sv
// 16-bit Galois LFSR used to generate lane obstacle patterns.
// next_state exposes the value the register will take on the next enabled edge.
module frog_lfsr16
    import frog_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        load_seed,
    output logic [15:0] state,
    output logic [15:0] next_state
);

    assign next_state = next_lfsr(state);

    always_ff @(posedge clk) begin
        if (reset || load_seed) begin
            state <= SEED;
        end else if (enable) begin
            state <= next_state;
        end
    end

endmodule

// File: rtl/frog_game_ctrl.sv
// Top-level sequencer: loads lane patterns, runs play, tracks lives and level.
// Optional SCORE_EN adds a saturating score counter on the interface.
module frog_game_ctrl
    import frog_pkg::*;
#(
    parameter int          NUM_LANES   = 8,
    parameter int          LANE_W      = 16,
    parameter int          START_LIVES = 3,
    parameter int          MAX_LEVEL   = 7,
    parameter logic [7:0]  BASE_SPEED  = 8'd96,
    parameter logic [7:0]  SPEED_STEP  = 8'd12,
    parameter logic [7:0]  MIN_SPEED   = 8'd8,
    parameter int          HOLD_CYC    = 32,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic                clk,
    input  logic                reset,
    frog_game_ctrl_if.master    bus
);

    localparam int IDX_W  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int HOLD_W = $clog2(HOLD_CYC + 1);

    state_t                      state_q;
    logic [IDX_W-1:0]            idx_q;
    logic [HOLD_W-1:0]           hold_q;
    logic [3:0]                  level_q;
    logic [2:0]                  lives_q;
    logic [NUM_LANES*LANE_W-1:0] init_q;
    logic [7:0]                  speed_q;
    logic                        lane_reset_q;
    logic                        play_en_q;
    logic                        game_over_q;
    logic                        win_q;
    logic [15:0]                 lfsr_state;
    logic [15:0]                 lfsr_next;

    frog_lfsr16 #(
        .SEED (SEED)
    ) u_lfsr (
        .clk        (clk),
        .reset      (reset),
        .enable     (state_q == LOAD),
        .load_seed  (1'b0),
        .state      (lfsr_state),
        .next_state (lfsr_next)
    );

    // Speed shrinks per level but clamps at the floor instead of wrapping
    function automatic logic [7:0] speed_for(input logic [3:0] lvl);
        logic [11:0] drop;
        logic [8:0]  diff;
        drop = 12'(lvl) * 12'(SPEED_STEP);
        if (drop >= 12'(BASE_SPEED)) begin
            return MIN_SPEED;
        end
        diff = 9'(12'(BASE_SPEED) - drop);
        return (diff < 9'(MIN_SPEED)) ? MIN_SPEED : diff[7:0];
    endfunction

`ifdef SCORE_EN
    logic [15:0] score_q;
    logic [16:0] score_sum;

    assign score_sum = 17'(score_q) + (17'(level_q) + 17'd1) * 17'd16;
    assign bus.score = score_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            hold_q       <= '0;
            level_q      <= '0;
            lives_q      <= '0;
            init_q       <= '0;
            speed_q      <= BASE_SPEED;
            lane_reset_q <= 1'b1;
            play_en_q    <= 1'b0;
            game_over_q  <= 1'b0;
            win_q        <= 1'b0;
`ifdef SCORE_EN
            score_q      <= '0;
`endif
        end else begin
            speed_q <= speed_for(level_q);
            case (state_q)
                IDLE, OVER, WIN: begin
                    if (bus.start) begin
                        state_q      <= LOAD;
                        lives_q      <= 3'(START_LIVES);
                        level_q      <= '0;
                        idx_q        <= '0;
                        lane_reset_q <= 1'b1;
                        game_over_q  <= 1'b0;
                        win_q        <= 1'b0;
`ifdef SCORE_EN
                        score_q      <= '0;
`endif
                    end
                end
                LOAD: begin
                    init_q[int'(idx_q)*LANE_W +: LANE_W] <= LANE_W'(lfsr_next & GAP_MASK);
                    if (idx_q == IDX_W'(NUM_LANES - 1)) begin
                        state_q <= ARM;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                ARM: begin
                    state_q      <= RUN;
                    lane_reset_q <= 1'b0;
                    play_en_q    <= 1'b1;
                end
                RUN: begin
                    // A hit wins over a simultaneous goal
                    if (bus.lose_any) begin
                        play_en_q <= 1'b0;
                        if (lives_q <= 3'd1) begin
                            lives_q      <= '0;
                            state_q      <= OVER;
                            game_over_q  <= 1'b1;
                            lane_reset_q <= 1'b1;
                        end else begin
                            lives_q <= lives_q - 3'd1;
                            state_q <= HIT;
                            hold_q  <= '0;
                        end
                    end else if (bus.goal) begin
                        play_en_q    <= 1'b0;
                        lane_reset_q <= 1'b1;
`ifdef SCORE_EN
                        score_q      <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
`endif
                        if (level_q == 4'(MAX_LEVEL)) begin
                            state_q <= WIN;
                            win_q   <= 1'b1;
                        end else begin
                            level_q <= level_q + 4'd1;
                            idx_q   <= '0;
                            state_q <= LOAD;
                        end
                    end
                end
                HIT: begin
                    if (hold_q == HOLD_W'(HOLD_CYC - 1)) begin
                        state_q      <= LOAD;
                        idx_q        <= '0;
                        lane_reset_q <= 1'b1;
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    lane_reset_q <= 1'b1;
                    play_en_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.lane_reset = lane_reset_q;
    assign bus.init_bus   = init_q;
    assign bus.speed      = speed_q;
    assign bus.level      = level_q;
    assign bus.lives      = lives_q;
    assign bus.play_en    = play_en_q;
    assign bus.game_over  = game_over_q;
    assign bus.win        = win_q;

endmodule

// File: tb/tb_frog_game_ctrl.sv
// Randomized self-checking bench for frog_game_ctrl against a game-rule model.
// Score checks are compiled in when SCORE_EN is defined.
module tb_frog_game_ctrl;

    localparam int NL    = 8;
    localparam int LW    = 16;
    localparam int HOLD  = 32;
    localparam int MAXL  = 7;
    localparam int LIVES = 3;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    frog_game_ctrl_if #(.NUM_LANES(NL), .LANE_W(LW)) bus ();

    frog_game_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int fails  = 0;

    logic [15:0] m_lfsr;
    int          m_lives;
    int          m_level;
    int          m_score;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit s, input bit l, input bit g);
        bus.start    = s;
        bus.lose_any = l;
        bus.goal     = g;
    endtask

    // Pattern generator model written from the shift/tap rule
    function automatic logic [15:0] model_step(input logic [15:0] s);
        int v;
        v = int'(s) / 2;
        if (int'(s) % 2 == 1) v = v ^ 'hB400;
        return 16'(v);
    endfunction

    function automatic int model_speed(input int lvl);
        int s;
        s = 96 - lvl * 12;
        return (s < 8) ? 8 : s;
    endfunction

    task automatic checkRunState(input string tag);
        checkOutput({tag, " lives"}, 32'(bus.lives), 32'(m_lives));
        checkOutput({tag, " level"}, 32'(bus.level), 32'(m_level));
        checkOutput({tag, " speed"}, 32'(bus.speed), 32'(model_speed(m_level)));
        checkOutput({tag, " lane_reset"}, 32'(bus.lane_reset), 32'd0);
        checkOutput({tag, " flags"}, {30'd0, bus.game_over, bus.win}, 32'd0);
`ifdef SCORE_EN
        checkOutput({tag, " score"}, 32'(bus.score), 32'(m_score));
`endif
    endtask

    // Steps from the triggering edge until play resumes, then checks the new patterns
    task automatic waitForRun(input string tag, input int exp_ticks, input int start_hold);
        int n;
        int lr_cnt;
        n = 0;
        lr_cnt = 0;
        while (n < 200) begin
            tick();
            n++;
            bus.lose_any = 1'b0;
            bus.goal     = 1'b0;
            if (n >= start_hold) bus.start = 1'b0;
            if (bus.play_en === 1'b1) break;
            if (bus.lane_reset === 1'b1) lr_cnt++;
        end
        bus.start = 1'b0;
        checkOutput({tag, " cycles to run"}, 32'(n), 32'(exp_ticks));
        checkOutput({tag, " lane_reset cycles"}, 32'(lr_cnt), 32'(NL + 1));
        for (int i = 0; i < NL; i++) begin
            m_lfsr = model_step(m_lfsr);
            checkOutput($sformatf("%s word%0d", tag, i),
                        32'(bus.init_bus[i*LW +: LW]), 32'(m_lfsr & 16'h7777));
        end
        checkRunState(tag);
    endtask

    task automatic newGame(input string tag);
        m_lives = LIVES;
        m_level = 0;
        m_score = 0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitForRun(tag, NL + 2, int'($urandom_range(1, 12)));
    endtask

    task automatic runNoise(input string tag);
        int k;
        k = int'($urandom_range(1, 4));
        for (int i = 0; i < k; i++) begin
            applyStimulus(1'($urandom), 1'b0, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput({tag, " play_en"}, 32'(bus.play_en), 32'd1);
        checkOutput({tag, " lives"}, 32'(bus.lives), 32'(m_lives));
    endtask

    task automatic doHit(input string tag, input bit with_goal);
        m_lives--;
        applyStimulus(1'b0, 1'b1, with_goal);
        waitForRun(tag, HOLD + NL + 2, 0);
    endtask

    task automatic doGoal(input string tag);
        m_score = m_score + 16 * (m_level + 1);
        if (m_score > 65535) m_score = 65535;
        m_level++;
        applyStimulus(1'b0, 1'b0, 1'b1);
        waitForRun(tag, NL + 2, 0);
    endtask

    task automatic checkIdleLike(input string tag, input int exp_over, input int exp_win);
        checkOutput({tag, " lane_reset"}, 32'(bus.lane_reset), 32'd1);
        checkOutput({tag, " play_en"}, 32'(bus.play_en), 32'd0);
        checkOutput({tag, " game_over"}, 32'(bus.game_over), 32'(exp_over));
        checkOutput({tag, " win"}, 32'(bus.win), 32'(exp_win));
        checkOutput({tag, " lives"}, 32'(bus.lives), 32'(m_lives));
    endtask

    task automatic inputNoise(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            applyStimulus(1'b0, 1'($urandom), 1'($urandom));
            tick();
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick();
        tick();
        m_lfsr  = 16'hACE1;
        m_lives = 0;
        m_level = 0;
        m_score = 0;
        checkOutput("reset init_bus", 32'(bus.init_bus != '0), 32'd0);
        checkOutput("reset speed", 32'(bus.speed), 32'd96);
        checkOutput("reset level", 32'(bus.level), 32'd0);
        checkIdleLike("reset", 0, 0);
        reset = 1'b0;

        inputNoise(3);
        checkIdleLike("idle noise", 0, 0);

        newGame("start");
        runNoise("run noise");
        doHit("hit1", 1'b0);
        doHit("hit+goal", 1'b1);
        for (int lvl = 0; lvl < MAXL; lvl++) begin
            doGoal($sformatf("goal L%0d", lvl));
            if ($urandom_range(0, 1) == 1) runNoise("goal noise");
        end

        m_score = m_score + 16 * (m_level + 1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkIdleLike("win", 0, 1);
        checkOutput("win level", 32'(bus.level), 32'(MAXL));
`ifdef SCORE_EN
        checkOutput("win score", 32'(bus.score), 32'(m_score));
`endif
        inputNoise(4);
        checkIdleLike("win noise", 0, 1);

        newGame("restart from win");
        while (m_lives > 1) doHit("hit to over", 1'b0);
        m_lives = 0;
        applyStimulus(1'b0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkIdleLike("over", 1, 0);
        inputNoise(4);
        checkIdleLike("over noise", 1, 0);

        newGame("restart from over");
        doGoal("goal before reset");

        // Reset after four pattern words have been written
        applyStimulus(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            applyStimulus(1'b0, 1'b0, 1'b0);
        end
        reset = 1'b1;
        tick();
        m_lfsr  = 16'hACE1;
        m_lives = 0;
        m_level = 0;
        m_score = 0;
        checkOutput("mid reset init_bus", 32'(bus.init_bus != '0), 32'd0);
        checkOutput("mid reset speed", 32'(bus.speed), 32'd96);
        checkOutput("mid reset level", 32'(bus.level), 32'd0);
`ifdef SCORE_EN
        checkOutput("mid reset score", 32'(bus.score), 32'd0);
`endif
        checkIdleLike("mid reset", 0, 0);
        reset = 1'b0;
        tick();
        newGame("start after reset");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
